// File: rtl/fft_ram_pkg.sv
// Shared defaults and requester encoding for the FFT RAM arbiter.
package fft_ram_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned BURST_MAX = 4;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_port_arb.sv
// Two-way round-robin arbiter for one RAM port, with a burst limit that only
// applies while both requesters are contending.
module rr_port_arb #(
  parameter int unsigned BURST_MAX = fft_ram_pkg::BURST_MAX
) (
  input  logic CLK,
  input  logic RST,
  input  logic want_a,
  input  logic want_b,
  output logic gnt_a,
  output logic gnt_b
);
  import fft_ram_pkg::*;

  localparam logic [3:0] BurstLast = 4'(BURST_MAX - 1);

  req_id_e    prio_q, prio_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    gnt_a  = 1'b0;
    gnt_b  = 1'b0;
    prio_d = prio_q;
    cnt_d  = 4'd0;
    if (!RST) begin
      if (want_a && want_b) begin
        gnt_a = (prio_q == REQ_A);
        gnt_b = !gnt_a;
        // Hand priority over after the holder's last allowed contended grant.
        if (cnt_q == BurstLast) begin
          prio_d = (prio_q == REQ_A) ? REQ_B : REQ_A;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else if (want_a) begin
        gnt_a  = 1'b1;
        prio_d = REQ_A;
      end else if (want_b) begin
        gnt_b  = 1'b1;
        prio_d = REQ_B;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prio_q <= REQ_A;
      cnt_q  <= 4'd0;
    end else begin
      prio_q <= prio_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/fft_ram_arbiter.sv
// Shares one 256x16 block RAM between the sample loader (A) and the FFT core (B),
// arbitrating the read and write ports independently.
module fft_ram_arbiter #(
  parameter int unsigned ADDR_W    = fft_ram_pkg::ADDR_W,
  parameter int unsigned DATA_W    = fft_ram_pkg::DATA_W,
  parameter int unsigned BURST_MAX = fft_ram_pkg::BURST_MAX
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_mask
);
  import fft_ram_pkg::*;

  logic rd_gnt_a, rd_gnt_b, wr_gnt_a, wr_gnt_b;

  rr_port_arb #(
    .BURST_MAX(BURST_MAX)
  ) u_rd_arb (
    .CLK   (CLK),
    .RST   (RST),
    .want_a(a_req && !a_we),
    .want_b(b_req && !b_we),
    .gnt_a (rd_gnt_a),
    .gnt_b (rd_gnt_b)
  );

  rr_port_arb #(
    .BURST_MAX(BURST_MAX)
  ) u_wr_arb (
    .CLK   (CLK),
    .RST   (RST),
    .want_a(a_req && a_we),
    .want_b(b_req && b_we),
    .gnt_a (wr_gnt_a),
    .gnt_b (wr_gnt_b)
  );

  logic [ADDR_W-1:0] raddr_q, waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_pend_q;
  req_id_e           rd_owner_q;

  assign a_ready  = rd_gnt_a || wr_gnt_a;
  assign b_ready  = rd_gnt_b || wr_gnt_b;
  assign ram_mask = '0;

  // Idle ports keep presenting the last address/data they carried.
  always_comb begin
    ram_re    = rd_gnt_a || rd_gnt_b;
    ram_we    = wr_gnt_a || wr_gnt_b;
    ram_raddr = raddr_q;
    ram_waddr = waddr_q;
    ram_wdata = wdata_q;
    if (rd_gnt_a) ram_raddr = a_addr;
    if (rd_gnt_b) ram_raddr = b_addr;
    if (wr_gnt_a) begin
      ram_waddr = a_addr;
      ram_wdata = a_wdata;
    end
    if (wr_gnt_b) begin
      ram_waddr = b_addr;
      ram_wdata = b_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      raddr_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= REQ_A;
    end else begin
      raddr_q   <= ram_raddr;
      waddr_q   <= ram_waddr;
      wdata_q   <= ram_wdata;
      rd_pend_q <= ram_re;
      if (ram_re) rd_owner_q <= rd_gnt_b ? REQ_B : REQ_A;
    end
  end

  always_comb begin
    a_rvalid = rd_pend_q && (rd_owner_q == REQ_A);
    b_rvalid = rd_pend_q && (rd_owner_q == REQ_B);
    a_rdata  = a_rvalid ? ram_rdata : '0;
    b_rdata  = b_rvalid ? ram_rdata : '0;
  end

endmodule

// File: doc/fft_ram_arbiter.md
Name: fft_ram_arbiter

Overview:
- Shares one 256x16 SB_RAM40_4K block between two requesters: A (sample loader/output drain) and B (FFT butterfly core).
- The RAM's independent read and write ports are arbitrated separately, so one requester can read while the other writes in the same cycle.
- Each port uses round-robin arbitration with a bounded burst hold.
- Read responses are tagged back to the requester that issued them, one cycle after acceptance, matching the RAM's registered read.

Parameters:
- ADDR_W, 8, RAM address width (256 words at 16 bits).
- DATA_W, 16, RAM data width.
- BURST_MAX, 4, maximum consecutive grants of one port to one requester while the other requester is waiting (1..15).

Ports:
- CLK  in  1  system clock; the RAM's RCLK/WCLK share it.
- RST  in  1  synchronous reset, active-high.
- a_req  in  1  A request valid; A holds all request fields stable until accepted.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_W  A word address.
- a_wdata  in  DATA_W  A write data.
- a_ready  out  1  A request accepted this cycle (transfer = a_req & a_ready).
- a_rvalid  out  1  A read data valid.
- a_rdata  out  DATA_W  A read data.
- b_req, b_we, b_addr, b_wdata, b_ready, b_rvalid, b_rdata: same as A, for requester B.
- ram_raddr  out  ADDR_W  to RAM RADDR.
- ram_re  out  1  to RAM RE.
- ram_rdata  in  DATA_W  from RAM RDATA.
- ram_waddr  out  ADDR_W  to RAM WADDR.
- ram_wdata  out  DATA_W  to RAM WDATA.
- ram_we  out  1  to RAM WE.
- ram_mask  out  DATA_W  to RAM MASK; constant all-zero (all bits written).

Behaviour:
- Clock and reset: one clock, CLK; reset RST is synchronous and active-high.
- Reset values: a_ready = b_ready = 0 while RST=1; rvalid outputs 0; ram_re = ram_we = 0; both port pointers favour A; both burst counters 0.
- Port demand: requester X wants the read port when X_req & !X_we, and the write port when X_req & X_we.
- Single contender: if only one requester wants a port, it is granted the same cycle.
- Two contenders: the winner is the requester holding priority. Priority passes to the other requester when either:
  - the holder's grant is its BURST_MAX-th consecutive grant while the other is waiting, or
  - the holder drops its request.
- Burst counter: one per port. It increments on each grant to the same requester while the other is waiting, and resets to 0 when ownership changes or the other requester is not waiting. With no contention there is no burst limit.
- Ready is combinational from req, we and the arbitration state: X_ready = grant to X on the port X wants. There is no combinational path from ready to req.
- RAM drive: ram_raddr/ram_re come from the read-port winner and ram_waddr/ram_wdata/ram_we from the write-port winner, all combinational. ram_re = 0 and ram_we = 0 when the port is idle; address and data hold their last value.
- Read latency: exactly 1 cycle. An accepted read sets rd_owner_q and rd_pend_q. The next cycle asserts X_rvalid for that owner only, with X_rdata = ram_rdata passed through. The non-owner's rdata is 0. Back-to-back reads give one rvalid per cycle.
- Same-address read and write in the same cycle: the read returns the old contents (RAM behaviour). The arbiter does no forwarding.
- Reset mid-operation: a read accepted in the cycle RST rises produces no rvalid. Pointers and counters return to their reset values.
- Address wrap: the full range 0..2^ADDR_W-1 is valid with no checking.

Decomposition:
- Package fft_ram_pkg holds ADDR_W, DATA_W, BURST_MAX defaults and the requester ID encoding (REQ_A = 0, REQ_B = 1).
- Sub-module rr_port_arb holds the 2-way round-robin with burst counter and priority register. It is instantiated twice, once for the read port and once for the write port.
- Read-response tagging and RAM muxing live in the top.

Test Plan:
- A reads address 0x05 alone (RAM preloaded 0x0105) -> a_ready in cycle 0; a_rvalid = 1 with a_rdata = 0x0105 in cycle 1; b_rvalid stays 0.
- A writes 0x10 = 0xBEEF while B reads 0x20 in the same cycle -> both ready in the same cycle; ram_we = 1 with waddr 0x10; b_rvalid the next cycle with the 0x20 contents.
- A and B both stream reads continuously for 12 cycles, BURST_MAX = 4 -> grant pattern AAAABBBBAAAA; every rvalid is tagged to the correct owner.
- Both write to 0x30 in the same cycle (A = 0x1111, B = 0x2222), priority on A -> A is written first, B the next cycle; a later read of 0x30 returns 0x2222.
- Write 0x40 = 0xCAFE and read 0x40 in the same cycle (old value 0x0000) -> read returns 0x0000; a read the next cycle returns 0xCAFE.
- Assert RST in the cycle a B read is accepted -> b_rvalid never pulses; after release A wins first contention.
